// File: rtl/control_sequencer_if.sv
// Control bundle between the Mini SRC sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Mem_Ready;
  logic        Stop;
  logic        PC_Out;
  logic        MDR_Out;
  logic        ZHI_Out;
  logic        ZLO_Out;
  logic        HI_Out;
  logic        LO_Out;
  logic        C_Out;
  logic        PC_In;
  logic        IncPC;
  logic        MAR_In;
  logic        MDR_In;
  logic        IR_In;
  logic        Y_In;
  logic        HI_In;
  logic        LO_In;
  logic [15:0] R_Out;
  logic [15:0] R_In;
  logic        Read;
  logic        Write;
  logic [3:0]  CONTROL;
  logic        Run;

  modport master (
    input  IR, Mem_Ready, Stop,
    output PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out,
    output PC_In, IncPC, MAR_In, MDR_In, IR_In, Y_In, HI_In, LO_In,
    output R_Out, R_In, Read, Write, CONTROL, Run
  );

  modport slave (
    output IR, Mem_Ready, Stop,
    input  PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out,
    input  PC_In, IncPC, MAR_In, MDR_In, IR_In, Y_In, HI_In, LO_In,
    input  R_Out, R_In, Read, Write, CONTROL, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus Mini SRC.
// Outputs are a Moore decode of the T-state and the live IR.
module control_sequencer #(
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input logic Clock,
  input logic Clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  state_t state;

  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [15:0] oh_ra, oh_rb, oh_rc, base;
  logic [3:0]  alu_op;
  logic        unused_ir;

  assign op = bus.IR[31:27];
  assign ra = bus.IR[26:23];
  assign rb = bus.IR[22:19];
  assign rc = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

  assign oh_ra = 16'h1 << ra;
  assign oh_rb = 16'h1 << rb;
  assign oh_rc = 16'h1 << rc;
  // R0 as a base register means absolute addressing: nothing drives the bus
  assign base  = (rb != 4'd0) ? oh_rb : 16'h0;

  logic is_alu, is_imm, is_md, is_un;
  logic is_ldi, is_ld, is_st, is_addr;
  logic is_mfhi, is_mflo, is_nop, is_halt;
  logic is_legal, to_halt, last3;
  state_t nxt_fetch;

  assign is_alu  = (op >= 5'd3) && (op <= 5'd10);
  assign is_imm  = (op >= 5'd11) && (op <= 5'd13);
  assign is_md   = (op == 5'd14) || (op == 5'd15);
  assign is_un   = (op == 5'd16) || (op == 5'd17);
  assign is_ld   = (op == 5'd0);
  assign is_ldi  = (op == 5'd1);
  assign is_st   = (op == 5'd2);
  assign is_addr = is_ld | is_ldi | is_st;
  assign is_mfhi = (op == 5'd24);
  assign is_mflo = (op == 5'd25);
  assign is_nop  = (op == 5'd26);
  assign is_halt = (op == 5'd27);

  assign is_legal = is_alu | is_imm | is_md | is_un | is_addr |
                    is_mfhi | is_mflo | is_nop | is_halt;
  assign to_halt  = is_halt | (!is_legal && !NOP_ON_ILLEGAL);
  assign last3    = is_mfhi | is_mflo | is_nop |
                    (!is_legal && NOP_ON_ILLEGAL);

  // Stop is only looked at on the way into a new fetch
  assign nxt_fetch = bus.Stop ? S_PAUSE : S_T0;

  // ALU op code for the opcode groups that use the ALU
  always_comb begin
    alu_op = 4'd0;
    unique case (1'b1)
      is_alu: alu_op = op[3:0] - 4'd3;
      is_imm: alu_op = (op == 5'd11) ? 4'd0 :
                       (op == 5'd12) ? 4'd2 : 4'd3;
      is_md:  alu_op = {3'b100, op[0]};
      is_un:  alu_op = {3'b101, op[0]};
      default: ;
    endcase
  end

  // T-state sequencing with memory waits, pause and halt
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= S_RST;
    end else begin
      unique case (state)
        S_RST:   state <= S_T0;
        S_PAUSE: if (!bus.Stop) state <= S_T0;
        S_HALT:  state <= S_HALT;
        S_T0:    state <= S_T1;
        S_T1:    if (bus.Mem_Ready) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (to_halt)    state <= S_HALT;
          else if (last3) state <= nxt_fetch;
          else            state <= S_T4;
        end
        S_T4:    state <= is_un ? nxt_fetch : S_T5;
        S_T5: begin
          if (is_ld || is_st || is_md) state <= S_T6;
          else                         state <= nxt_fetch;
        end
        S_T6: begin
          if (is_md)               state <= nxt_fetch;
          else if (!is_ld)         state <= S_T7;
          else if (bus.Mem_Ready)  state <= S_T7;
        end
        S_T7: begin
          if (is_ld || bus.Mem_Ready) state <= nxt_fetch;
        end
        default: state <= S_RST;
      endcase
    end
  end

  // Moore decode of control lines from state and IR
  always_comb begin
    bus.PC_Out  = 1'b0;
    bus.MDR_Out = 1'b0;
    bus.ZHI_Out = 1'b0;
    bus.ZLO_Out = 1'b0;
    bus.HI_Out  = 1'b0;
    bus.LO_Out  = 1'b0;
    bus.C_Out   = 1'b0;
    bus.PC_In   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MAR_In  = 1'b0;
    bus.MDR_In  = 1'b0;
    bus.IR_In   = 1'b0;
    bus.Y_In    = 1'b0;
    bus.HI_In   = 1'b0;
    bus.LO_In   = 1'b0;
    bus.R_Out   = 16'h0;
    bus.R_In    = 16'h0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.CONTROL = 4'd0;
    bus.Run     = (state != S_HALT);
    unique case (state)
      S_T0: begin
        bus.PC_Out = 1'b1;
        bus.MAR_In = 1'b1;
        bus.IncPC  = 1'b1;
      end
      S_T1: begin
        bus.Read   = 1'b1;
        bus.MDR_In = 1'b1;
      end
      S_T2: begin
        bus.MDR_Out = 1'b1;
        bus.IR_In   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_alu, is_imm: begin
            bus.R_Out = oh_rb;
            bus.Y_In  = 1'b1;
          end
          is_addr: begin
            bus.R_Out = base;
            bus.Y_In  = 1'b1;
          end
          is_md: begin
            bus.R_Out = oh_ra;
            bus.Y_In  = 1'b1;
          end
          is_un: begin
            bus.R_Out   = oh_rb;
            bus.CONTROL = alu_op;
          end
          is_mfhi: begin
            bus.HI_Out = 1'b1;
            bus.R_In   = oh_ra;
          end
          is_mflo: begin
            bus.LO_Out = 1'b1;
            bus.R_In   = oh_ra;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          is_alu: begin
            bus.R_Out   = oh_rc;
            bus.CONTROL = alu_op;
          end
          is_imm, is_addr: begin
            bus.C_Out   = 1'b1;
            bus.CONTROL = alu_op;
          end
          is_md: begin
            bus.R_Out   = oh_rb;
            bus.CONTROL = alu_op;
          end
          is_un: begin
            bus.ZLO_Out = 1'b1;
            bus.R_In    = oh_ra;
          end
          default: ;
        endcase
      end
      S_T5: begin
        bus.ZLO_Out = 1'b1;
        unique case (1'b1)
          is_alu, is_imm, is_ldi: bus.R_In = oh_ra;
          is_ld, is_st:           bus.MAR_In = 1'b1;
          is_md:                  bus.LO_In = 1'b1;
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          is_ld: begin
            bus.Read   = 1'b1;
            bus.MDR_In = 1'b1;
          end
          is_st: begin
            bus.R_Out  = oh_ra;
            bus.MDR_In = 1'b1;
          end
          is_md: begin
            bus.ZHI_Out = 1'b1;
            bus.HI_In   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          is_ld: begin
            bus.MDR_Out = 1'b1;
            bus.R_In    = oh_ra;
          end
          is_st:   bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sequences the single-bus Mini SRC datapath through fetch and execute.
- Decodes the IR and drives every bus gate, register-enable, memory strobe and ALU CONTROL line.
- Waits on a memory-ready handshake for all memory cycles.
- Sits beside the datapath; consumes IR contents and Mem_Ready; drives Run/halt status to the top level.

Parameters:
- NOP_ON_ILLEGAL, 1, 1: undefined opcode executes as nop. 0: undefined opcode enters HALT.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Clear  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents. opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Mem_Ready  in  1  memory completes current Read/Write on this cycle.
- Stop  in  1  pause request, honoured at fetch boundary.
- PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out  out  1 each  bus source gates.
- PC_In, IncPC, MAR_In, MDR_In, IR_In, Y_In, HI_In, LO_In  out  1 each  register loads.
- R_Out  out  16  one-hot-or-zero GPR bus gate, bit n = Rn_Out.
- R_In  out  16  one-hot-or-zero GPR load, bit n = Rn_In.
- Read, Write  out  1 each  memory strobes. Read also selects MData_In into MDR.
- CONTROL  out  4  ALU op code.
- Run  out  1  high unless in HALT.

Behaviour:
- Clear low (any time, including mid-instruction or mid-wait):
  - State becomes RST.
  - All outputs are 0 except Run=1; CONTROL=0.
  - First rising edge after release goes to T0.
- Outputs are a Moore function of state plus IR.
- Fetch:
  - T0: PC_Out, MAR_In, IncPC.
  - T1: Read, MDR_In. Hold T1 (outputs unchanged) while Mem_Ready=0.
  - T2: MDR_Out, IR_In.
  - T3: first execute state, dispatched on opcode.
- Stop:
  - Sampled only when entering T0.
  - If high, hold in PAUSE (all outputs 0, Run=1) until Stop low, then T0.
  - An instruction already in progress always completes.
- ALU timing: Z is captured on the edge ending the cycle in which the second operand is on the bus; ZLO/ZHI are valid the next cycle.
- CONTROL codes: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, ROR=6, ROL=7, MUL=8, DIV=9, NEG=10, NOT=11. CONTROL is held 0 outside ALU cycles.
- Execute sequences (after the last listed step, return to T0):
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010:
    - T3: R_Out[Rb], Y_In.
    - T4: R_Out[Rc], CONTROL=op.
    - T5: ZLO_Out, R_In[Ra].
  - addi 01011, andi 01100, ori 01101:
    - T3: R_Out[Rb], Y_In.
    - T4: C_Out, CONTROL=ADD/AND/OR.
    - T5: ZLO_Out, R_In[Ra].
  - mul 01110, div 01111:
    - T3: R_Out[Ra], Y_In.
    - T4: R_Out[Rb], CONTROL.
    - T5: ZLO_Out, LO_In.
    - T6: ZHI_Out, HI_In.
  - neg 10000, not 10001:
    - T3: R_Out[Rb], CONTROL.
    - T4: ZLO_Out, R_In[Ra].
  - ldi 00001:
    - T3: base, Y_In.
    - T4: C_Out, ADD.
    - T5: ZLO_Out, R_In[Ra].
  - ld 00000:
    - T3–T4 as ldi.
    - T5: ZLO_Out, MAR_In.
    - T6: Read, MDR_In; wait on Mem_Ready.
    - T7: MDR_Out, R_In[Ra].
  - st 00010:
    - T3–T5 as ld.
    - T6: R_Out[Ra], MDR_In (Read=0).
    - T7: Write; wait on Mem_Ready.
  - mfhi 11000: T3: HI_Out, R_In[Ra].
  - mflo 11001: T3: LO_Out, R_In[Ra].
  - nop 11010: T3 to T0, no outputs.
  - halt 11011: go to HALT. Run=0, all outputs 0, stays until Clear.
- Address base:
  - Rb≠0: R_Out[Rb].
  - Rb=0: R_Out=0, so the bus reads 0 (Bus32 drives 0 with no source selected).
- Invariants:
  - At most one bus source active per cycle.
  - R_In and R_Out never both non-zero in the same cycle.
- Wait states: Mem_Ready=1 on the first cycle of T1/T6/T7 means no wait state is added.

Test Plan:
- Reset then fetch, Mem_Ready tied 1, IR=0x18000000 (add R0,R0,R0):
  - T0 shows PC_Out, MAR_In, IncPC.
  - T1 shows Read, MDR_In; T2 shows MDR_Out, IR_In.
  - T5 asserts R_In=0x0001.
  - Back at T0 on the 7th cycle.
- Mem_Ready low 3 cycles during T1:
  - Read and MDR_In stay high for 4 cycles.
  - IR_In asserts exactly once.
- ld R2,0x65(R0), IR=0x01000065:
  - T3 has R_Out=0.
  - T4 has C_Out, CONTROL=0.
  - T7 asserts MDR_Out and R_In=0x0004.
- mul R3,R1, IR=0x71880000:
  - T3 R_Out=0x0008; T4 R_Out=0x0002, CONTROL=8.
  - T5 LO_In, T6 HI_In.
- Clear pulsed low during the st write wait:
  - Write drops immediately (asynchronously).
  - After release, the sequence restarts at T0.
- halt opcode 11011:
  - Run goes 0 and stays 0 for 20 cycles.
  - Stop toggling has no effect.
  - Only Clear recovers.
